prll_bs_rr_sched: RTL and testbench
===================================

PRLL_BS_RR_SCHED -- requirements
Module: prll_bs_rr_sched

Interface
REQ-001 SHALL have parameter drvrs, default 9: number of driver ports sharing the bus.
REQ-002 SHALL have parameter bits, default 32: data word width.
REQ-003 SHALL have parameter id_w, default 8: destination-ID field width, located in D_pop[bits-1 -: id_w].
REQ-004 SHALL have parameter broadcast, default {8{1'b1}}: destination ID meaning "all drivers".
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pndng, input, drvrs: driver d's FIFO is non-empty; its head word is valid on D_pop (first-word fall-through).
REQ-008 SHALL have port D_pop, input, drvrs*bits: flattened head words; driver d occupies [d*bits +: bits].
REQ-009 SHALL have port pop, output, drvrs: one-cycle pop strobe to the granted driver's FIFO.
REQ-010 SHALL have port push, output, drvrs: one-cycle push strobe(s) to the destination driver(s).
REQ-011 SHALL have port D_push, output, bits: shared bus word, common to all destinations.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port grant_id, output, $clog2(drvrs): index of the current or last granted driver.

Function
REQ-014 SHALL implement FSM IDLE -> POP -> PUSH -> IDLE; each transfer takes exactly 3 cycles.
REQ-015 IDLE: if |pndng, SHALL latch the winner (see REQ-016) into grant_id and go to POP; otherwise SHALL stay in IDLE.
REQ-016 Winner SHALL be the first d with pndng[d]=1, searching from rr_ptr upward and wrapping from drvrs-1 to 0.
REQ-017 POP: SHALL assert pop[grant_id] for exactly one cycle and capture D_pop[grant_id] into the data register.
REQ-018 pndng SHALL be sampled only in IDLE; a pndng drop during POP SHALL NOT cancel the pop.
REQ-019 PUSH: D_push SHALL equal the captured word, held from PUSH until the next capture.
REQ-020 PUSH, dest < drvrs: SHALL assert push[dest] for one cycle; dest == grant_id is delivered (loopback).
REQ-021 PUSH, dest == broadcast: SHALL assert push[d] for every d except grant_id.
REQ-022 PUSH, dest >= drvrs and dest != broadcast: SHALL assert no push; the word is dropped.
REQ-023 On leaving PUSH, rr_ptr SHALL become (grant_id+1) mod drvrs.
REQ-024 pop and push SHALL be registered outputs and SHALL never both be high in the same cycle.

Reset
REQ-025 With reset low, SHALL immediately force: state IDLE; rr_ptr, grant_id and the data register to 0; pop, push and busy to 0; D_push to 0.
REQ-026 Reset asserted during POP or PUSH SHALL abort the transfer; an already-popped word is lost.

Configuration
REQ-027 With macro PRLL_BS_SCHED_STATS_EN defined, SHALL add outputs xfer_cnt[15:0] and drop_cnt[15:0].
REQ-028 xfer_cnt SHALL increment once per PUSH that delivers to at least one destination.
REQ-029 drop_cnt SHALL increment once per dropped word (REQ-022).
REQ-030 Both counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-031 Without PRLL_BS_SCHED_STATS_EN, the counters and their ports SHALL be absent; all other behaviour is unchanged.

Structure
REQ-032 Package prll_bs_pkg SHALL hold the FSM state enum (IDLE, POP, PUSH) and default constants for bits, id_w and broadcast.
REQ-033 Round-robin search SHALL be a combinational sub-module rr_pick: inputs req and ptr, outputs any and idx.

Verification
REQ-034 Bench SHALL cover: reset low, then pndng=0 -> busy=0, pop=0, push=0 for 20 cycles.
REQ-035 Bench SHALL cover: pndng[2]=1, D_pop[2]=32'h05_00ABCD -> pop[2] in cycle 2, push[5] in cycle 3, D_push=32'h0500ABCD.
REQ-036 Bench SHALL cover: pndng=9'h1FF held, each driver always has data -> grants in order 0,1,…,8,0, one grant per 3 cycles.
REQ-037 Bench SHALL cover: driver 4 word with ID 8'hFF -> push=9'h1EF (all but bit 4); driver 1 word with ID 8'h0C -> push=0, drop_cnt +1 with PRLL_BS_SCHED_STATS_EN.
REQ-038 Bench SHALL cover: reset pulsed low during PUSH -> push drops to 0 asynchronously; next grant after release starts at driver 0.
REQ-039 Bench SHALL cover: 65540 deliveries with PRLL_BS_SCHED_STATS_EN -> xfer_cnt=16'hFFFF (saturated).

Source files
------------

// File: rtl/prll_bs_pkg.sv
// Shared types and default constants for the parallel-bus round-robin scheduler.
package prll_bs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    localparam int unsigned DEF_BITS      = 32;
    localparam int unsigned DEF_ID_W      = 8;
    localparam logic [7:0]  DEF_BROADCAST = {8{1'b1}};

endpackage

// File: rtl/prll_bs_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at n-1.
module rr_pick
    import prll_bs_pkg::*;
#(
    parameter int unsigned n = 9,
    parameter int unsigned w = 4
) (
    input  logic [n-1:0] req,
    input  logic [w-1:0] ptr,
    output logic         any,
    output logic [w-1:0] idx
);

    int unsigned cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int unsigned i = 0; i < n; i++) begin
            cand = (32'(ptr) + i) % n;
            if (!any && req[w'(cand)]) begin
                any = 1'b1;
                idx = w'(cand);
            end
        end
    end

endmodule

// File: rtl/prll_bs_rr_sched.sv
// Shared-bus scheduler: pops one word from a round-robin winner, pushes it to its destination(s).
// Optional transfer/drop statistics when PRLL_BS_SCHED_STATS_EN is defined.
module prll_bs_rr_sched
    import prll_bs_pkg::*;
#(
    parameter int unsigned     drvrs     = 9,
    parameter int unsigned     bits      = DEF_BITS,
    parameter int unsigned     id_w      = DEF_ID_W,
    parameter logic [id_w-1:0] broadcast = id_w'(DEF_BROADCAST),
    localparam int unsigned    gw        = (drvrs > 1) ? $clog2(drvrs) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [drvrs-1:0]      pndng,
    input  logic [drvrs*bits-1:0] D_pop,
    output logic [drvrs-1:0]      pop,
    output logic [drvrs-1:0]      push,
    output logic [bits-1:0]       D_push,
    output logic                  busy,
    output logic [gw-1:0]         grant_id
`ifdef PRLL_BS_SCHED_STATS_EN
    ,
    output logic [15:0]           xfer_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    state_t           state;
    logic [gw-1:0]    rr_ptr;
    logic [bits-1:0]  data;
    logic             win_any;
    logic [gw-1:0]    win_idx;
    logic [drvrs-1:0] pop_next;
    logic [bits-1:0]  head;
    logic [id_w-1:0]  dest;
    logic [31:0]      dest_ext;
    logic [drvrs-1:0] push_next;
    logic             is_drop;

    rr_pick #(
        .n (drvrs),
        .w (gw)
    ) u_rr_pick (
        .req (pndng),
        .ptr (rr_ptr),
        .any (win_any),
        .idx (win_idx)
    );

    always_comb begin
        pop_next = '0;
        for (int unsigned d = 0; d < drvrs; d++)
            pop_next[d] = (gw'(d) == win_idx);
    end

    // Destination decode works on the granted driver's head word, valid throughout POP.
    always_comb begin
        head = '0;
        for (int unsigned d = 0; d < drvrs; d++)
            if (gw'(d) == grant_id)
                head = D_pop[d*bits +: bits];
        dest                 = head[bits-1 -: id_w];
        dest_ext             = '0;
        dest_ext[id_w-1:0]   = dest;
        push_next            = '0;
        is_drop              = 1'b0;
        if (dest == broadcast) begin
            for (int unsigned d = 0; d < drvrs; d++)
                push_next[d] = (gw'(d) != grant_id);
        end else if (dest_ext < 32'(drvrs)) begin
            for (int unsigned d = 0; d < drvrs; d++)
                push_next[d] = (32'(d) == dest_ext);
        end else begin
            is_drop = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            data     <= '0;
            pop      <= '0;
            push     <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    push <= '0;
                    if (win_any) begin
                        grant_id <= win_idx;
                        pop      <= pop_next;
                        busy     <= 1'b1;
                        state    <= POP;
                    end
                end
                POP: begin
                    pop   <= '0;
                    data  <= head;
                    push  <= push_next;
                    state <= PUSH;
                end
                PUSH: begin
                    push   <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (grant_id == gw'(drvrs - 1)) ? '0 : grant_id + 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    pop   <= '0;
                    push  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign D_push = data;

`ifdef PRLL_BS_SCHED_STATS_EN
    // Counted at the POP->PUSH edge, when the push vector is decided.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_cnt <= '0;
            drop_cnt <= '0;
        end else if (state == POP) begin
            if (push_next != '0 && xfer_cnt != '1)
                xfer_cnt <= xfer_cnt + 16'd1;
            if (is_drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prll_bs_rr_sched.sv
// Directed self-checking bench for prll_bs_rr_sched; stats checks need PRLL_BS_SCHED_STATS_EN.
module tb_prll_bs_rr_sched;

    logic         clk;
    logic         reset;
    logic [8:0]   pndng;
    logic [287:0] D_pop;
    logic [8:0]   pop;
    logic [8:0]   push;
    logic [31:0]  D_push;
    logic         busy;
    logic [3:0]   grant_id;
`ifdef PRLL_BS_SCHED_STATS_EN
    logic [15:0]  xfer_cnt;
    logic [15:0]  drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    prll_bs_rr_sched #(
        .drvrs (9),
        .bits  (32),
        .id_w  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .grant_id (grant_id)
`ifdef PRLL_BS_SCHED_STATS_EN
        ,
        .xfer_cnt (xfer_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_word(input int d, input logic [31:0] w);
        D_pop[d*32 +: 32] = w;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        pndng = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (pop !== 9'h000) begin n_err++; $display("FAIL reset_pop: got %h want 000", pop); end
        n_cmp++; if (push !== 9'h000) begin n_err++; $display("FAIL reset_push: got %h want 000", push); end
        n_cmp++; if (D_push !== 32'h0) begin n_err++; $display("FAIL reset_dpush: got %h want 0", D_push); end
        n_cmp++; if (grant_id !== 4'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0 || pop !== 9'h000 || push !== 9'h000) begin
                n_err++;
                $display("FAIL idle_quiet cyc %0d: busy=%b pop=%h push=%h want 0/000/000", i, busy, pop, push);
            end
        end
    endtask

    task automatic test_single();
        set_word(2, 32'h0500ABCD);
        pndng = 9'h004;
        tick();
        n_cmp++; if (pop !== 9'h004) begin n_err++; $display("FAIL single_pop: got %h want 004", pop); end
        n_cmp++; if (grant_id !== 4'd2) begin n_err++; $display("FAIL single_grant: got %0d want 2", grant_id); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
        pndng = 9'h000;
        tick();
        n_cmp++; if (push !== 9'h020) begin n_err++; $display("FAIL single_push: got %h want 020", push); end
        n_cmp++; if (pop !== 9'h000) begin n_err++; $display("FAIL single_pop_off: got %h want 000", pop); end
        n_cmp++; if (D_push !== 32'h0500ABCD) begin n_err++; $display("FAIL single_dpush: got %h want 0500abcd", D_push); end
        tick();
        n_cmp++; if (push !== 9'h000 || busy !== 1'b0) begin n_err++; $display("FAIL single_end: push=%h busy=%b want 000/0", push, busy); end
        n_cmp++; if (D_push !== 32'h0500ABCD) begin n_err++; $display("FAIL single_hold: got %h want 0500abcd", D_push); end
    endtask

    task automatic test_round_robin();
        logic [8:0]  exp_v;
        logic [31:0] exp_w;
        int          d;
        pulse_reset();
        for (int k = 0; k < 9; k++)
            set_word(k, {8'(k), 24'hA00000 + 24'(k)});
        pndng = 9'h1FF;
        for (int k = 0; k < 10; k++) begin
            d = k % 9;
            exp_v = 9'h001 << d;
            exp_w = {8'(d), 24'hA00000 + 24'(d)};
            tick();
            n_cmp++; if (pop !== exp_v || grant_id !== 4'(d)) begin n_err++; $display("FAIL rr_pop %0d: pop=%h grant=%0d want %h/%0d", k, pop, grant_id, exp_v, d); end
            tick();
            n_cmp++; if (push !== exp_v || D_push !== exp_w) begin n_err++; $display("FAIL rr_push %0d: push=%h data=%h want %h/%h", k, push, D_push, exp_v, exp_w); end
            tick();
            n_cmp++; if (pop !== 9'h000 || push !== 9'h000) begin n_err++; $display("FAIL rr_idle %0d: pop=%h push=%h want 000/000", k, pop, push); end
        end
        pndng = '0;
    endtask

    task automatic test_dest_decode();
        logic [15:0] drops0;
        drops0 = '0;
        pulse_reset();
        set_word(4, 32'hFF123456);
        pndng = 9'h010;
        tick();
        n_cmp++; if (pop !== 9'h010) begin n_err++; $display("FAIL bcast_pop: got %h want 010", pop); end
        pndng = '0;
        tick();
        n_cmp++; if (push !== 9'h1EF || D_push !== 32'hFF123456) begin n_err++; $display("FAIL bcast_push: push=%h data=%h want 1ef/ff123456", push, D_push); end
        tick();
`ifdef PRLL_BS_SCHED_STATS_EN
        drops0 = drop_cnt;
`endif
        set_word(1, 32'h0C777777);
        pndng = 9'h002;
        tick();
        n_cmp++; if (pop !== 9'h002) begin n_err++; $display("FAIL drop_pop: got %h want 002", pop); end
        pndng = '0;
        tick();
        n_cmp++; if (push !== 9'h000 || busy !== 1'b1) begin n_err++; $display("FAIL drop_push: push=%h busy=%b want 000/1", push, busy); end
        n_cmp++; if (D_push !== 32'h0C777777) begin n_err++; $display("FAIL drop_data: got %h want 0c777777", D_push); end
        tick();
`ifdef PRLL_BS_SCHED_STATS_EN
        n_cmp++; if (drop_cnt !== drops0 + 16'd1) begin n_err++; $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, drops0 + 16'd1); end
`endif
        set_word(0, 32'h08000001);
        pndng = 9'h001;
        tick();
        pndng = '0;
        tick();
        n_cmp++; if (push !== 9'h100) begin n_err++; $display("FAIL dest8_push: got %h want 100", push); end
        tick();
        set_word(0, 32'h09000002);
        pndng = 9'h001;
        tick();
        pndng = '0;
        tick();
        n_cmp++; if (push !== 9'h000) begin n_err++; $display("FAIL dest9_push: got %h want 000", push); end
        tick();
    endtask

    task automatic test_reset_abort();
        pulse_reset();
        set_word(5, 32'h00000055);
        pndng = 9'h020;
        tick();
        pndng = '0;
        tick();
        tick();
        set_word(6, 32'h02000066);
        pndng = 9'h040;
        tick();
        n_cmp++; if (pop !== 9'h040) begin n_err++; $display("FAIL abort_pop: got %h want 040", pop); end
        tick();
        n_cmp++; if (push !== 9'h004) begin n_err++; $display("FAIL abort_push_pre: got %h want 004", push); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (push !== 9'h000 || busy !== 1'b0) begin n_err++; $display("FAIL abort_async: push=%h busy=%b want 000/0", push, busy); end
        n_cmp++; if (D_push !== 32'h0) begin n_err++; $display("FAIL abort_dpush: got %h want 0", D_push); end
        @(negedge clk);
        set_word(0, 32'h03000000);
        pndng = 9'h041;
        reset = 1'b1;
        tick();
        n_cmp++; if (pop !== 9'h001 || grant_id !== 4'd0) begin n_err++; $display("FAIL abort_next: pop=%h grant=%0d want 001/0", pop, grant_id); end
        pndng = '0;
        tick();
        tick();
    endtask

`ifdef PRLL_BS_SCHED_STATS_EN
    task automatic test_stats_saturate();
        pulse_reset();
        n_cmp++; if (xfer_cnt !== 16'd0 || drop_cnt !== 16'd0) begin n_err++; $display("FAIL stats_reset: xfer=%0d drop=%0d want 0/0", xfer_cnt, drop_cnt); end
        set_word(0, 32'h01000000);
        pndng = 9'h001;
        tick();
        tick();
        tick();
        n_cmp++; if (xfer_cnt !== 16'd1) begin n_err++; $display("FAIL stats_one: got %0d want 1", xfer_cnt); end
        for (int i = 1; i < 65540; i++) begin
            tick();
            tick();
            tick();
        end
        pndng = '0;
        tick();
        n_cmp++; if (xfer_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stats_sat: got %h want ffff", xfer_cnt); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL stats_nodrop: got %0d want 0", drop_cnt); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_dest_decode();
        test_reset_abort();
`ifdef PRLL_BS_SCHED_STATS_EN
        test_stats_saturate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
